// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues word fetches to a registered-read bank,
// buffers returned words in a 2-entry queue and hands them to decode.
module fetch_sequencer #(
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter int                 MEM_BYTES = 256
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [31:0]       imem_data_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic              halt_i,
   output logic              instr_valid_o,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] instr_pc_o,
   input  logic              instr_ready_i,
   output logic              halted_o,
   output logic              fault_o
);

   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 4);

   typedef enum logic [1:0] {S_RUN, S_HALTED, S_FAULT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
   logic [1:0]        count_q, count_d;
   logic [31:0]       q0_data_q, q0_data_d, q1_data_q, q1_data_d;
   logic [ADDR_W-1:0] q0_pc_q, q0_pc_d, q1_pc_q, q1_pc_d;

   logic       pop, push, want, issue, pc_ok, redir_act, redir_bad, go_fault;
   logic [1:0] occ;

   always_comb begin
      instr_valid_o = (count_q != 2'd0) && (state_q != S_FAULT);
      instr_o       = instr_valid_o ? q0_data_q : 32'd0;
      instr_pc_o    = instr_valid_o ? q0_pc_q : '0;
      halted_o      = (state_q == S_HALTED);
      fault_o       = (state_q == S_FAULT);

      pop       = instr_valid_o && instr_ready_i;
      // A same-cycle pop frees a slot, which keeps the stream at one word per cycle.
      occ       = count_q + {1'b0, inflight_q} - {1'b0, pop};
      redir_act = redirect_valid_i && (state_q != S_FAULT);
      redir_bad = (redirect_pc_i[1:0] != 2'b00) || (redirect_pc_i > LAST_PC);
      pc_ok     = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
      want      = !reset && (state_q == S_RUN) && !halt_i && !redirect_valid_i && (occ < 2'd2);
      issue     = want && pc_ok;
      go_fault  = (redir_act && redir_bad) || (want && !pc_ok);
      push      = inflight_q && !redir_act;

      imem_addr_o = issue ? pc_q : addr_q;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      inflight_d = issue;
      infl_pc_d  = issue ? pc_q : infl_pc_q;
      count_d    = count_q;
      q0_data_d  = q0_data_q;
      q0_pc_d    = q0_pc_q;
      q1_data_d  = q1_data_q;
      q1_pc_d    = q1_pc_q;

      unique case (state_q)
         S_RUN: begin
            if (go_fault)                  state_d = S_FAULT;
            else if (halt_i && !inflight_q) state_d = S_HALTED;
         end
         S_HALTED: begin
            if (go_fault)     state_d = S_FAULT;
            else if (!halt_i) state_d = S_RUN;
         end
         default: state_d = S_FAULT;
      endcase

      if (redir_act)  pc_d = redirect_pc_i;
      else if (issue) pc_d = pc_q + ADDR_W'(4);
      if (issue) addr_d = pc_q;

      if (redir_act || go_fault) begin
         count_d = 2'd0;
      end else if (push && pop) begin
         if (count_q == 2'd1) begin
            q0_data_d = imem_data_i;
            q0_pc_d   = infl_pc_q;
         end else begin
            q0_data_d = q1_data_q;
            q0_pc_d   = q1_pc_q;
            q1_data_d = imem_data_i;
            q1_pc_d   = infl_pc_q;
         end
      end else if (push) begin
         count_d = count_q + 2'd1;
         if (count_q == 2'd0) begin
            q0_data_d = imem_data_i;
            q0_pc_d   = infl_pc_q;
         end else begin
            q1_data_d = imem_data_i;
            q1_pc_d   = infl_pc_q;
         end
      end else if (pop) begin
         count_d   = count_q - 2'd1;
         q0_data_d = q1_data_q;
         q0_pc_d   = q1_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_RUN;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
      end
   end

   // Payload registers carry no reset; count_q and the output gating mask stale contents.
   always_ff @(posedge clk) begin
      infl_pc_q <= infl_pc_d;
      q0_data_q <= q0_data_d;
      q0_pc_q   <= q0_pc_d;
      q1_data_q <= q1_data_d;
      q1_pc_q   <= q1_pc_d;
   end

endmodule
